// File: rtl/swap_scheduler_pkg.sv
// Shared types for the double-buffer swap scheduler.
package swap_scheduler_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StDrawing,
        StWaitVblank,
        StSwap,
        StHold,
        StAck
    } swap_state_t;

    typedef struct packed {
        logic [15:0] frame_count;
        logic [15:0] missed_count;
        logic [7:0]  fps;
    } swap_stats_t;

    localparam logic [7:0]  Sat8  = 8'hFF;
    localparam logic [15:0] Sat16 = 16'hFFFF;

    // Saturating 8-bit increment.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val, input logic inc);
        logic [7:0] res;
        res = val;
        if (inc && (val != Sat8)) begin
            res = val + 8'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/swap_scheduler_vblank_rate_meter.sv
// Frame-rate meter: counts swaps over a window of vblank pulses and
// publishes the count as fps when the window closes.
module vblank_rate_meter
    import swap_scheduler_pkg::*;
#(
    parameter int unsigned VBLANKS_PER_SEC = 60
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       vblank_start,
    input  logic       swap,
    output logic [7:0] fps
);

    localparam int unsigned WinW = (VBLANKS_PER_SEC > 1) ? $clog2(VBLANKS_PER_SEC) : 1;
    localparam logic [WinW-1:0] WinLast = WinW'(VBLANKS_PER_SEC - 1);

    logic [WinW-1:0] win_cnt;
    logic [7:0]      swap_cnt;
    logic [7:0]      swap_total;

    // Includes a swap landing in the very cycle the window closes.
    assign swap_total = sat_inc8(swap_cnt, swap);

    // Window and swap counters; publish and clear at the end of each window.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_cnt  <= '0;
            swap_cnt <= '0;
            fps      <= '0;
        end else if (vblank_start && (win_cnt == WinLast)) begin
            fps      <= swap_total;
            win_cnt  <= '0;
            swap_cnt <= '0;
        end else begin
            if (vblank_start) begin
                win_cnt <= win_cnt + 1'b1;
            end
            swap_cnt <= swap_total;
        end
    end

endmodule

// File: rtl/swap_scheduler.sv
// Double-buffer sequencer: starts and releases the drawing manager, swaps
// draw/display buffers only on vblank, routes the draw write port and keeps
// frame statistics.
module swap_scheduler
    import swap_scheduler_pkg::*;
#(
    parameter int unsigned BUFFER_ADDR_WIDTH = 15,
    parameter int unsigned BUFFER_DATA_WIDTH = 12,
    parameter int unsigned MIN_VBLANKS       = 1,
    parameter int unsigned VBLANKS_PER_SEC   = 60
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         enable,
    input  logic                         vblank_start,
    input  logic                         frame_done,
    output logic                         draw_start,
    output logic                         draw_ack,
    output logic                         draw_buffer,
    output logic                         display_buffer,
    input  logic                         wr_en,
    input  logic [BUFFER_ADDR_WIDTH-1:0] wr_addr,
    input  logic [BUFFER_DATA_WIDTH-1:0] wr_data,
    output logic                         buf0_we,
    output logic                         buf1_we,
    output logic [BUFFER_ADDR_WIDTH-1:0] buf_addr,
    output logic [BUFFER_DATA_WIDTH-1:0] buf_data,
    output logic [15:0]                  frame_count,
    output logic [15:0]                  missed_count,
    output logic [7:0]                   fps
);

    localparam logic [8:0] MinVblanks = 9'(MIN_VBLANKS);

    swap_state_t state;
    logic [7:0]  vcnt;
    logic [15:0] frame_cnt;
    logic [15:0] missed_cnt;
    logic [7:0]  fps_val;
    logic        swap_ok;
    logic        in_swap;
    logic        deadline_miss;
    swap_stats_t stats;

    // The current pulse counts toward the minimum, hence the +1.
    assign swap_ok = ({1'b0, vcnt} + 9'd1) >= MinVblanks;
    assign in_swap = (state == StSwap);

    // A deadline is missed when a vblank could have swapped but no frame is ready.
    assign deadline_miss = vblank_start && swap_ok &&
                           ((state == StStart) || ((state == StDrawing) && !frame_done));

    assign display_buffer = ~draw_buffer;
    assign buf0_we        = wr_en & ~draw_buffer;
    assign buf1_we        = wr_en & draw_buffer;
    assign buf_addr       = wr_addr;
    assign buf_data       = wr_data;

    // Sequencer FSM with registered draw_start/draw_ack and buffer select.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= StIdle;
            draw_start  <= 1'b0;
            draw_ack    <= 1'b0;
            draw_buffer <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            draw_start <= 1'b0;
            draw_ack   <= 1'b0;
            case (state)
                StIdle: begin
                    if (enable) begin
                        state      <= StStart;
                        draw_start <= 1'b1;
                    end
                end
                StStart: state <= StDrawing;
                StDrawing: begin
                    if (frame_done) begin
                        state <= (vblank_start && swap_ok) ? StSwap : StWaitVblank;
                    end
                end
                StWaitVblank: begin
                    if (vblank_start && swap_ok) begin
                        state <= StSwap;
                    end
                end
                StSwap: begin
                    draw_buffer <= ~draw_buffer;
                    frame_cnt   <= frame_cnt + 16'd1;
                    if (enable) begin
                        state    <= StAck;
                        draw_ack <= 1'b1;
                    end else begin
                        state <= StHold;
                    end
                end
                StHold: begin
                    if (enable) begin
                        state    <= StAck;
                        draw_ack <= 1'b1;
                    end
                end
                StAck:   state <= StDrawing;
                default: state <= StIdle;
            endcase
        end
    end

    // Vblanks since the last swap and saturating missed-deadline count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vcnt       <= '0;
            missed_cnt <= '0;
        end else begin
            if (in_swap) begin
                vcnt <= '0;
            end else if (vblank_start && (state != StIdle)) begin
                vcnt <= sat_inc8(vcnt, 1'b1);
            end
            if (deadline_miss && (missed_cnt != Sat16)) begin
                missed_cnt <= missed_cnt + 16'd1;
            end
        end
    end

    vblank_rate_meter #(
        .VBLANKS_PER_SEC(VBLANKS_PER_SEC)
    ) u_rate_meter (
        .clk         (clk),
        .rstn        (rstn),
        .vblank_start(vblank_start),
        .swap        (in_swap),
        .fps         (fps_val)
    );

    assign stats = '{frame_count: frame_cnt, missed_count: missed_cnt, fps: fps_val};

    assign frame_count  = stats.frame_count;
    assign missed_count = stats.missed_count;
    assign fps          = stats.fps;

endmodule
